sram_pattern_tester: RTL

- Upstream sequencer for sram_driver: sweeps the full SRAM, writing a deterministic address-derived pattern, then reading every location back and comparing it.
- Reports pass/fail, error count, first failing address and a handshake-timeout flag; LED/status logic in top consumes these.
- Replaces the free-running read sweep in top as the board bring-up test.

---
 rtl/sram_pkg.sv | 37 +++
 rtl/sram_access_handshake.sv | 83 ++++++++
 rtl/sram_pattern_tester.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM pattern tester.
// Contents: default widths, sequencer and handshake state encodings, and the
// address-derived test pattern function used both when writing and checking.
package sram_pkg;

  localparam int ADDR_WIDTH_DEF = 13;
  localparam int DATA_WIDTH_DEF = 8;

  // Sequencer states. The two-phase ready wait is owned by the handshake
  // block, so the sequencer only needs a single wait state per direction.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_CHECK,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_WAIT_LO,
    HS_WAIT_HI
  } hs_state_e;

  // Pattern: low dw bits of the address XOR the remaining high bits
  // (zero-extended) XOR the seed. Caller truncates to its data width.
  function automatic logic [31:0] pat(input logic [31:0] addr,
                                      input int unsigned dw,
                                      input logic [31:0] seed);
    logic [31:0] low_mask;
    low_mask = (32'd1 << dw) - 32'd1;
    return (addr & low_mask) ^ (addr >> dw) ^ seed;
  endfunction

endpackage

// File: rtl/sram_access_handshake.sv
// Two-phase start/ready handshake with the SRAM driver, plus watchdog.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   req_i        - one-cycle request from the sequencer (driver is ready)
//   ready_i      - driver ready
//   start_o      - registered one-cycle start pulse to the driver
//   ack_o        - one cycle: ready sampled high after having been low
//   timeout_o    - one cycle: a single ready edge took TIMEOUT cycles
module sram_access_handshake
  import sram_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  input  logic ready_i,
  output logic start_o,
  output logic ack_o,
  output logic timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  hs_state_e        state_q, state_d;
  logic             start_q, start_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    cnt_d     = cnt_q;
    ack_o     = 1'b0;
    timeout_o = 1'b0;
    case (state_q)
      HS_IDLE: begin
        if (req_i) begin
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = HS_WAIT_LO;
        end
      end
      HS_WAIT_LO: begin
        if (!ready_i) begin
          cnt_d   = '0;
          state_d = HS_WAIT_HI;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_o = 1'b1;
          state_d   = HS_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HS_WAIT_HI: begin
        if (ready_i) begin
          ack_o   = 1'b1;
          state_d = HS_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_o = 1'b1;
          state_d   = HS_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = HS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HS_IDLE;
      start_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
    end
  end

  assign start_o = start_q;

endmodule

// File: rtl/sram_pattern_tester.sv
// Board bring-up SRAM test sequencer: writes pat(a) to every address, then
// reads every address back and compares.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   go                - start a test (accepted in IDLE/DONE while ready)
//   busy, done, pass  - run status; pass valid while done
//   timeout           - sticky watchdog flag for the current run
//   error_count       - saturating mismatch count
//   first_err_addr    - address of first mismatch (0 if none)
//   ready, data_out   - from sram_driver
//   start, re, address, data_in - to sram_driver
module sram_pattern_tester
  import sram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] SEED       = DATA_WIDTH'(8'hA5),
  parameter int                    TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [15:0]           error_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  input  logic                  ready,
  output logic                  start,
  output logic                  re,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] data_out
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  state_e                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  timeout_q, timeout_d;
  logic                  re_q, re_d;
  logic [15:0]           err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0] first_err_q, first_err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic                  hs_req, hs_ack, hs_timeout;
  logic [DATA_WIDTH-1:0] addr_pat;

  assign addr_pat = DATA_WIDTH'(pat(32'(addr_q), DATA_WIDTH, 32'(SEED)));

  sram_access_handshake #(
    .TIMEOUT (TIMEOUT)
  ) u_handshake (
    .clk       (clk),
    .reset     (reset),
    .req_i     (hs_req),
    .ready_i   (ready),
    .start_o   (start),
    .ack_o     (hs_ack),
    .timeout_o (hs_timeout)
  );

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    re_d        = re_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    addr_d      = addr_q;
    data_in_d   = data_in_q;
    rd_data_d   = rd_data_q;
    hs_req      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // go while not ready is held off until the driver is idle.
        if (go && ready) begin
          busy_d      = 1'b1;
          done_d      = 1'b0;
          timeout_d   = 1'b0;
          err_cnt_d   = '0;
          first_err_d = '0;
          addr_d      = '0;
          state_d     = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        re_d      = 1'b0;
        data_in_d = addr_pat;
        hs_req    = 1'b1;
        state_d   = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (hs_timeout) begin
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end else if (hs_ack) begin
          if (addr_q == ADDR_MAX) begin
            addr_d  = '0;
            state_d = ST_RD_REQ;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_WR_REQ;
          end
        end
      end
      ST_RD_REQ: begin
        re_d    = 1'b1;
        hs_req  = 1'b1;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (hs_timeout) begin
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end else if (hs_ack) begin
          rd_data_d = data_out;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (rd_data_q != addr_pat) begin
          if (err_cnt_q == '0) first_err_d = addr_q;
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end
        if (addr_q == ADDR_MAX) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_RD_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      re_q        <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      addr_q      <= '0;
      data_in_q   <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      re_q        <= re_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      addr_q      <= addr_d;
      data_in_q   <= data_in_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = done_q && (err_cnt_q == '0) && !timeout_q;
  assign timeout        = timeout_q;
  assign error_count    = err_cnt_q;
  assign first_err_addr = first_err_q;
  assign re             = re_q;
  assign address        = addr_q;
  assign data_in        = data_in_q;

endmodule
